// File: rtl/tdc_event_arbiter.sv
// Merges NCHAN one-entry TDC channel holds into one FIFO stream, round-robin, tagged with channel index.
// Latency: one cycle from grant to wrEn/outData; one word per cycle while fifoFull is low.
// Backpressure: fifoFull stalls grants and holds pending entries; optional drop counter via TDC_ARB_DROPCNT_EN.
`timescale 1ns/1ps
module tdc_event_arbiter #(
    parameter int WORDSIZE = 16,
    parameter int NCHAN    = 4,
    localparam int CHBITS  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NCHAN*WORDSIZE-1:0]  chData,
    input  logic [NCHAN-1:0]           chWrEn,
    input  logic                       fifoFull,
    output logic [WORDSIZE+CHBITS-1:0] outData,
    output logic                       wrEn,
    output logic                       busy,
    output logic                       done,
    output logic [NCHAN-1:0]           ovfFlags,
    output logic [15:0]                dropCnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NCHAN-1:0]           pending_q, pending_d;
    logic [WORDSIZE-1:0]        hold_q [NCHAN];
    logic [WORDSIZE-1:0]        hold_d [NCHAN];
    logic [CHBITS-1:0]          last_q, last_d;
    logic                       wr_en_q, wr_en_d;
    logic [WORDSIZE+CHBITS-1:0] out_data_q, out_data_d;
    logic                       done_q, done_d;
    logic [NCHAN-1:0]           ovf_q, ovf_d;
    logic [NCHAN-1:0]           drop;
    logic [NCHAN-1:0]           hi_req;
    logic                       run_start;
    logic                       gnt_vld;
    logic [CHBITS-1:0]          gnt_idx;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !stop)     state_d = ST_RUN;
            ST_RUN:   if (stop)               state_d = ST_DRAIN;
            ST_DRAIN: if (pending_q == '0)    state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs and state-derived strobes
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done_d    = (state_q == ST_DRAIN) && (pending_q == '0);
        run_start = (state_q == ST_IDLE) && start && !stop;
    end

    // Round-robin: lowest pending channel above the last grant, else wrap to the lowest pending overall
    always_comb begin
        hi_req  = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCHAN; i++) begin
            hi_req[i] = pending_q[i] && (i > int'(last_q));
        end
        if ((state_q != ST_IDLE) && !fifoFull) begin
            if (hi_req != '0) begin
                for (int i = NCHAN - 1; i >= 0; i--) begin
                    if (hi_req[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = CHBITS'(i);
                    end
                end
            end else begin
                for (int i = NCHAN - 1; i >= 0; i--) begin
                    if (pending_q[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = CHBITS'(i);
                    end
                end
            end
        end
    end

    // Grant frees the slot first, so an event landing in its own grant cycle reloads instead of dropping
    always_comb begin
        pending_d = pending_q;
        drop      = '0;
        for (int i = 0; i < NCHAN; i++) begin
            hold_d[i] = hold_q[i];
        end
        if (gnt_vld) begin
            pending_d[gnt_idx] = 1'b0;
        end
        for (int i = 0; i < NCHAN; i++) begin
            if ((state_q == ST_RUN) && chWrEn[i]) begin
                if (pending_d[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    hold_d[i]    = chData[i*WORDSIZE +: WORDSIZE];
                end
            end
        end
    end

    always_comb begin
        wr_en_d    = gnt_vld;
        out_data_d = gnt_vld ? {gnt_idx, hold_q[gnt_idx]} : out_data_q;
        last_d     = gnt_vld ? gnt_idx : last_q;
        ovf_d      = run_start ? '0 : (ovf_q | drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            last_q     <= CHBITS'(NCHAN - 1);
            wr_en_q    <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            last_q     <= last_d;
            wr_en_q    <= wr_en_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Hold data is only ever read behind a pending flag, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCHAN; i++) begin
            hold_q[i] <= hold_d[i];
        end
    end

`ifdef TDC_ARB_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] cnt_sum;

    always_comb begin
        cnt_sum = 32'(drop_cnt_q) + 32'($countones(drop));
        if (run_start) begin
            drop_cnt_d = '0;
        end else if (cnt_sum > 32'h0000_FFFF) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropCnt = drop_cnt_q;
`else
    assign dropCnt = '0;
`endif

    assign wrEn     = wr_en_q;
    assign outData  = out_data_q;
    assign done     = done_q;
    assign ovfFlags = ovf_q;

endmodule

// File: doc/tdc_event_arbiter.md
TDC_EVENT_ARBITER -- requirements
Module: tdc_event_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 16: width of each channel's delta-T word.
REQ-002 Parameter NCHAN, default 4: number of TDC channels merged; CHBITS = clog2(NCHAN), minimum 1.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse that begins acquisition.
REQ-006 stop  input  1  single-cycle pulse that ends acquisition and drains pending events.
REQ-007 chData  input  NCHAN*WORDSIZE  per-channel delta-T words; channel i occupies bits [i*WORDSIZE +: WORDSIZE].
REQ-008 chWrEn  input  NCHAN  per-channel event strobes, each one cycle wide.
REQ-009 fifoFull  input  1  downstream FIFO full flag.
REQ-010 outData  output  WORDSIZE+CHBITS  merged word: {channel index, delta-T}.
REQ-011 wrEn  output  1  downstream FIFO write strobe for outData.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse when DRAIN completes.
REQ-014 ovfFlags  output  NCHAN  sticky per-channel drop flags.
REQ-015 dropCnt  output  16  total count of dropped events.

Function
REQ-016 The state machine has three states, IDLE, RUN and DRAIN, with these transitions:
- IDLE to RUN on start, unless stop is also high.
- RUN to DRAIN on stop; start in RUN is ignored.
- DRAIN to IDLE in the first cycle in which no hold register is pending.
- done is asserted in the cycle after the DRAIN-to-IDLE transition.
REQ-017 Each channel has a one-entry hold register (pending flag plus WORDSIZE data); events are captured only in RUN.
REQ-018 In RUN, chWrEn[i] with channel i not pending loads chData slice i and sets pending[i].
REQ-019 In RUN, chWrEn[i] with pending[i] set and channel i not granted that cycle discards the event, sets ovfFlags[i] and increments dropCnt.
REQ-020 chWrEn[i] in the same cycle that channel i is granted loads the new word with no drop.
REQ-021 Events arriving in IDLE or DRAIN are ignored: not stored and not counted.
REQ-022 Grant rule: in RUN or DRAIN, when fifoFull is low and any channel is pending, exactly one channel is granted per cycle.
REQ-023 Grant priority is round-robin, starting from the channel after the last granted channel.
REQ-024 Granting clears the channel's pending flag and updates the last-granted pointer.
REQ-025 wrEn and outData are registered; they appear exactly one cycle after the grant cycle, and wrEn stays high for one cycle per grant.
REQ-026 When fifoFull is high no grant occurs and pending entries hold; fifoFull is sampled only in the grant cycle.
REQ-027 Throughput is one word per cycle while the FIFO is not full.
REQ-028 outData holds its last value when wrEn is low.
REQ-029 dropCnt saturates at 16'hFFFF.
REQ-030 ovfFlags and dropCnt clear on an IDLE-to-RUN transition.

Reset
REQ-031 rst takes effect at the next clock edge regardless of state and overrides start and stop.
REQ-032 Values after reset:
- State is IDLE and all pending flags are 0.
- Last-granted pointer is NCHAN-1, so channel 0 has first priority.
- wrEn, outData, busy, done, ovfFlags and dropCnt are all 0.
REQ-033 rst asserted in RUN or DRAIN discards every pending event with no output write.

Configuration
REQ-034 Macro TDC_ARB_DROPCNT_EN controls the drop counter:
- Defined: the 16-bit saturating dropCnt is implemented as specified.
- Undefined: no counter logic; dropCnt is tied to 0; ovfFlags still operate.

Verification
REQ-035 After reset and start, drive chWrEn=4'b1111 for one cycle with data 10,20,30,40 and fifoFull=0. Over four consecutive cycles wrEn=1 with outData {0,10}, {1,20}, {2,30}, {3,40}, and dropCnt=0.
REQ-036 In RUN with fifoFull=1, pulse chWrEn[2] twice with data 5 then 6. ovfFlags=4'b0100 and dropCnt=1. After fifoFull drops, exactly one write of {2,5} occurs.
REQ-037 Channel 1 is pending, and chWrEn[1] with data 9 arrives in its grant cycle. The output is {1,old}, then {1,9}, with no drop.
REQ-038 Stop with three channels pending and fifoFull=0. Three writes occur, then IDLE with done=1 for one cycle and busy=0. A chWrEn during DRAIN produces no write.
REQ-039 Assert rst in RUN with two channels pending. The next cycle has wrEn=0, busy=0 and dropCnt=0, and no later writes occur.
REQ-040 Drive 65537 drops. With TDC_ARB_DROPCNT_EN defined, dropCnt=16'hFFFF. Undefined, dropCnt=0 while ovfFlags is still set.
